controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller_pkg.sv | 39 +++
 rtl/controller_aludec.sv | 31 +++
 rtl/controller.sv | 101 ++++++++++
 tb/tb_controller.sv | 133 +++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared encodings for the single-cycle RISC-V controller: opcodes, ALU
// operations, write-back and immediate selects, and main-decoder ALUOp classes.
package controller_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

endpackage

// File: rtl/controller_aludec.sv
// ALU decoder: maps the main decoder's ALUOp class plus funct fields to an
// ALUControl operation code.
module aludec
  import controller_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // sub only for R-type with funct7b5; addi never subtracts
          3'b000:  ALUControl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Single-cycle controller: combinational main decode and ALU decode, plus a
// sticky flag recording any unsupported opcode seen at a clock edge.
module controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [1:0] ResultSrc,
  output logic       MemWrite,
  output logic       PCSrc,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       Jump,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalOp
);

  logic       reg_write;
  logic       mem_write;
  logic       branch;
  logic       jump;
  logic       legal_op;
  logic [1:0] alu_op;
  logic       illegal_op_d;
  logic       illegal_op_q;

  always_comb begin
    reg_write = 1'b0;
    ImmSrc    = IMM_I;
    ALUSrc    = 1'b0;
    mem_write = 1'b0;
    ResultSrc = RES_ALU;
    branch    = 1'b0;
    alu_op    = ALUOP_ADD;
    jump      = 1'b0;
    legal_op  = 1'b1;
    case (op)
      OP_LOAD: begin
        reg_write = 1'b1;
        ALUSrc    = 1'b1;
        ResultSrc = RES_MEM;
      end
      OP_STORE: begin
        ImmSrc    = IMM_S;
        ALUSrc    = 1'b1;
        mem_write = 1'b1;
      end
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        ImmSrc = IMM_B;
        branch = 1'b1;
        alu_op = ALUOP_SUB;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        ALUSrc    = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_JAL: begin
        reg_write = 1'b1;
        ImmSrc    = IMM_J;
        ResultSrc = RES_PC4;
        jump      = 1'b1;
      end
      default: legal_op = 1'b0;
    endcase
  end

  aludec u_aludec (
    .opb5      (op[5]),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .ALUOp     (alu_op),
    .ALUControl(ALUControl)
  );

  // State-changing controls are suppressed while reset is held
  always_comb begin
    MemWrite     = mem_write & ~rst;
    RegWrite     = reg_write & ~rst;
    Jump         = jump & ~rst;
    PCSrc        = ((branch & Zero) | jump) & ~rst;
    illegal_op_d = illegal_op_q | ~legal_op;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_op_q <= 1'b0;
    else     illegal_op_q <= illegal_op_d;
  end

  assign IllegalOp = illegal_op_q;

endmodule

// File: tb/tb_controller.sv
// Directed-vector bench for the controller: decode table, ALU decode,
// branch/jump selection, reset gating and the sticky IllegalOp flag.
module tb_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [1:0] ResultSrc;
  logic       MemWrite;
  logic       PCSrc;
  logic       ALUSrc;
  logic       RegWrite;
  logic       Jump;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       IllegalOp;

  int n_chk  = 0;
  int n_pass = 0;

  controller dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .Zero      (Zero),
    .ResultSrc (ResultSrc),
    .MemWrite  (MemWrite),
    .PCSrc     (PCSrc),
    .ALUSrc    (ALUSrc),
    .RegWrite  (RegWrite),
    .Jump      (Jump),
    .ImmSrc    (ImmSrc),
    .ALUControl(ALUControl),
    .IllegalOp (IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {ResultSrc, MemWrite, PCSrc, ALUSrc, RegWrite, Jump, ImmSrc, ALUControl}
  logic [11:0] ctl;
  assign ctl = {ResultSrc, MemWrite, PCSrc, ALUSrc, RegWrite, Jump, ImmSrc, ALUControl};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Drive a new instruction at the falling edge, settle, leave time before the rising edge
  task automatic apply(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    @(negedge clk);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    #1;
  endtask

  initial begin
    rst = 1'b1; op = 7'b0100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    #1;
    chk("reset_illegal",    {31'd0, IllegalOp}, 32'd0);
    chk("reset_store_ctl",  {20'd0, ctl}, {20'd0, 12'b00_0_0_1_0_0_01_000});
    apply(7'b1101111, 3'b000, 1'b0, 1'b1);
    chk("reset_jal_ctl",    {20'd0, ctl}, {20'd0, 12'b10_0_0_0_0_0_11_000});

    @(negedge clk);
    rst = 1'b0;

    apply(7'b0000011, 3'b100, 1'b0, 1'b0);
    chk("load",      {20'd0, ctl}, {20'd0, 12'b01_0_0_1_1_0_00_000});
    apply(7'b0000011, 3'b010, 1'b1, 1'b1);
    chk("load_f7",   {20'd0, ctl}, {20'd0, 12'b01_0_0_1_1_0_00_000});
    apply(7'b0100011, 3'b011, 1'b1, 1'b1);
    chk("store",     {20'd0, ctl}, {20'd0, 12'b00_1_0_1_0_0_01_000});
    apply(7'b0110011, 3'b000, 1'b0, 1'b0);
    chk("r_add",     {20'd0, ctl}, {20'd0, 12'b00_0_0_0_1_0_00_000});
    apply(7'b0110011, 3'b000, 1'b1, 1'b0);
    chk("r_sub",     {20'd0, ctl}, {20'd0, 12'b00_0_0_0_1_0_00_001});
    apply(7'b0110011, 3'b010, 1'b0, 1'b0);
    chk("r_slt",     {29'd0, ALUControl}, 32'd5);
    apply(7'b0110011, 3'b110, 1'b0, 1'b0);
    chk("r_or",      {29'd0, ALUControl}, 32'd3);
    apply(7'b0110011, 3'b111, 1'b1, 1'b0);
    chk("r_and",     {29'd0, ALUControl}, 32'd2);
    apply(7'b0110011, 3'b001, 1'b0, 1'b0);
    chk("r_f3_001",  {29'd0, ALUControl}, 32'd0);
    apply(7'b0010011, 3'b000, 1'b1, 1'b0);
    chk("i_addi_f7", {20'd0, ctl}, {20'd0, 12'b00_0_0_1_1_0_00_000});
    apply(7'b0010011, 3'b010, 1'b0, 1'b0);
    chk("i_slti",    {20'd0, ctl}, {20'd0, 12'b00_0_0_1_1_0_00_101});
    apply(7'b1100011, 3'b000, 1'b0, 1'b1);
    chk("beq_taken", {20'd0, ctl}, {20'd0, 12'b00_0_1_0_0_0_10_001});
    apply(7'b1100011, 3'b000, 1'b0, 1'b0);
    chk("beq_not",   {20'd0, ctl}, {20'd0, 12'b00_0_0_0_0_0_10_001});
    apply(7'b1101111, 3'b111, 1'b1, 1'b0);
    chk("jal",       {20'd0, ctl}, {20'd0, 12'b10_0_1_0_1_1_11_000});
    chk("no_illegal_yet", {31'd0, IllegalOp}, 32'd0);

    apply(7'b1111111, 3'b010, 1'b1, 1'b1);
    chk("illegal_ctl", {20'd0, ctl}, {20'd0, 12'd0});
    @(posedge clk); #1;
    chk("illegal_set", {31'd0, IllegalOp}, 32'd1);
    apply(7'b0000011, 3'b000, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("illegal_held", {31'd0, IllegalOp}, 32'd1);
    chk("legal_after",  {20'd0, ctl}, {20'd0, 12'b01_0_0_1_1_0_00_000});

    @(negedge clk);
    rst = 1'b1; op = 7'b0100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    #1;
    chk("rst_clears",   {31'd0, IllegalOp}, 32'd0);
    chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);

    // Reset held across an edge with an unsupported opcode must keep the flag clear
    apply(7'b0000000, 3'b000, 1'b0, 1'b0);
    chk("zero_op_ctl", {20'd0, ctl}, {20'd0, 12'd0});
    @(posedge clk); #1;
    chk("rst_wins", {31'd0, IllegalOp}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("zero_op_sets", {31'd0, IllegalOp}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
